pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning datapath and address width.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 The ports SHALL be:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  hold PC (hazard unit)
branch_taken  in  1  conditional branch resolved taken in EX
branch_pc  in  N  PC of the resolving branch/JAL instruction
branch_offset  in  N  immediate already shifted left by one (shift-left stage output)
jalr_taken  in  1  JALR resolved in EX
jalr_base  in  N  rs1 value
jalr_imm  in  N  sign-extended I-immediate
halt_req  in  1  ECALL/EBREAK retired
resume  in  1  leave HALT
pc  out  N  current fetch address
pc_plus4  out  N  pc + 4
pc_valid  out  1  fetch address valid this cycle
redirect  out  1  registered flush pulse to IF/ID
halted  out  1  state == HALT
fault  out  1  state == FAULT
fault_addr  out  N  offending target address
fetch_count  out  N  count of PC advances

Function
REQ-005 FSM states SHALL be RUN, HALT, FAULT; reset state RUN.
REQ-006 Branch target SHALL be branch_pc + branch_offset, modulo 2^N, carry discarded.
REQ-007 JALR target SHALL be (jalr_base + jalr_imm) with bit 0 cleared, modulo 2^N.
REQ-008 In RUN, next-PC priority SHALL be: jalr_taken, then branch_taken, then stall (hold), then pc + 4.
REQ-009 Redirects SHALL override stall in the same cycle.
REQ-010 If the selected redirect target has bit 1 set, PC SHALL hold, state SHALL go to FAULT, and fault_addr SHALL capture the target, all on the same edge.
REQ-011 redirect SHALL pulse high for exactly one cycle after any accepted (non-faulting) redirect edge.
REQ-012 pc_valid SHALL be high only in RUN and low whenever stall is high.
REQ-013 fetch_count SHALL increment by 1 on every edge where PC changes in RUN, wrapping at 2^N - 1 to 0.
REQ-014 halt_req in RUN SHALL apply the same-cycle PC update (redirect or sequential), then enter HALT.
REQ-015 In HALT, PC SHALL hold and redirect/branch inputs SHALL be ignored; resume SHALL return to RUN next edge with PC unchanged.
REQ-016 halt_req and resume both high in HALT SHALL keep HALT.
REQ-017 FAULT SHALL be sticky until reset; PC, fault_addr, fetch_count hold.
REQ-018 pc_plus4 SHALL be combinational pc + 4, wrapping at 2^N.
REQ-019 PC wrap: pc = 2^N - 4 sequential advance SHALL produce 0.

Reset
REQ-020 On rst asserted: pc = RESET_VECTOR, state RUN, redirect 0, fault_addr 0, fetch_count 0, halted 0, fault 0, regardless of clock.
REQ-021 Reset mid-redirect or in HALT/FAULT SHALL discard pending state; first post-reset edge with no inputs SHALL give pc = RESET_VECTOR + 4.

Structure
REQ-022 FSM state encoding (2-bit enum RUN/HALT/FAULT) and the PC increment constant 4 SHALL live in a shared package pc_pkg.
REQ-023 Target computation SHALL be a sub-module pc_target_gen (combinational, both adders plus the bit-0 mask and misalignment flag); PC register, FSM, counter stay in pc_unit.

Verification
REQ-024 Reset then 3 idle edges -> pc 0x0,0x4,0x8,0xC; fetch_count 3.
REQ-025 pc=0x10, branch_pc=0x8, branch_offset=0x20, branch_taken with stall=1 -> next pc 0x28, redirect=1 one cycle, fetch_count +1.
REQ-026 jalr_base=0x101, jalr_imm=0x4, jalr_taken and branch_taken together -> pc 0x104 (JALR wins, bit 0 cleared).
REQ-027 jalr_base=0x100, jalr_imm=0x2 -> fault=1, fault_addr 0x102, pc held; later inputs ignored until rst.
REQ-028 pc=0x20, halt_req -> pc 0x24, halted=1, pc_valid=0; 5 idle cycles hold 0x24; resume -> RUN, next edge 0x28.
REQ-029 pc=0xFFFF_FFFC idle -> pc 0x0; rst asserted asynchronously mid-cycle -> pc 0x0 and fetch_count 0 before next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and
// the sequential fetch increment.
package pc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } pc_state_t;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_target_gen.sv
// Redirect target generation: branch and JALR adders, JALR bit-0 mask,
// priority selection (JALR over branch) and misalignment flag on bit 1.
module pc_target_gen #(
    parameter int unsigned N = 32
) (
    input  logic         branch_taken,
    input  logic [N-1:0] branch_pc,
    input  logic [N-1:0] branch_offset,
    input  logic         jalr_taken,
    input  logic [N-1:0] jalr_base,
    input  logic [N-1:0] jalr_imm,
    output logic [N-1:0] target,
    output logic         take,
    output logic         misaligned
);

    logic [N-1:0] branch_target;
    logic [N-1:0] jalr_sum;
    logic [N-1:0] jalr_target;

    // Both adders wrap modulo 2^N; JALR result has bit 0 forced low
    always_comb begin
        branch_target = branch_pc + branch_offset;
        jalr_sum      = jalr_base + jalr_imm;
        jalr_target   = {jalr_sum[N-1:1], 1'b0};
        take          = jalr_taken | branch_taken;
        target        = jalr_taken ? jalr_target : branch_target;
        misaligned    = target[1];
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, RUN/HALT/FAULT control FSM, registered
// redirect pulse, fault address capture and PC-advance counter.
module pc_unit #(
    parameter int unsigned    N            = 32,
    parameter logic [N-1:0]   RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_pc,
    input  logic [N-1:0] branch_offset,
    input  logic         jalr_taken,
    input  logic [N-1:0] jalr_base,
    input  logic [N-1:0] jalr_imm,
    input  logic         halt_req,
    input  logic         resume,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         pc_valid,
    output logic         redirect,
    output logic         halted,
    output logic         fault,
    output logic [N-1:0] fault_addr,
    output logic [N-1:0] fetch_count
);

    import pc_pkg::*;

    pc_state_t    state;
    pc_state_t    state_next;
    logic [N-1:0] pc_next;
    logic [N-1:0] target;
    logic         take;
    logic         misaligned;
    logic         redirect_next;
    logic         fault_capture;
    logic         advance;

    pc_target_gen #(
        .N (N)
    ) u_target_gen (
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .branch_offset (branch_offset),
        .jalr_taken    (jalr_taken),
        .jalr_base     (jalr_base),
        .jalr_imm      (jalr_imm),
        .target        (target),
        .take          (take),
        .misaligned    (misaligned)
    );

    // Status outputs derived directly from the current state
    always_comb begin
        pc_plus4 = pc + N'(PC_INCR);
        pc_valid = (state == RUN) && !stall;
        halted   = (state == HALT);
        fault    = (state == FAULT);
    end

    // Next-state / next-PC: redirects beat stall; a misaligned redirect
    // freezes the PC and traps; halt_req still applies this cycle's update
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = 1'b0;
        fault_capture = 1'b0;
        case (state)
            RUN: begin
                if (take && misaligned) begin
                    state_next    = FAULT;
                    fault_capture = 1'b1;
                end else begin
                    if (take) begin
                        pc_next       = target;
                        redirect_next = 1'b1;
                    end else if (!stall) begin
                        pc_next = pc_plus4;
                    end
                    if (halt_req) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_next = RUN;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        advance = (state == RUN) && (pc_next != pc);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // PC, redirect pulse, fault address and advance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            redirect    <= 1'b0;
            fault_addr  <= '0;
            fetch_count <= '0;
        end else begin
            pc       <= pc_next;
            redirect <= redirect_next;
            if (fault_capture) begin
                fault_addr <= target;
            end
            if (advance) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] branch_offset;
    logic        jalr_taken;
    logic [31:0] jalr_base;
    logic [31:0] jalr_imm;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pc_unit #(
        .N            (32),
        .RESET_VECTOR (RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .branch_offset (branch_offset),
        .jalr_taken    (jalr_taken),
        .jalr_base     (jalr_base),
        .jalr_imm      (jalr_imm),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .redirect      (redirect),
        .halted        (halted),
        .fault         (fault),
        .fault_addr    (fault_addr),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=running, 1=halted, 2=faulted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_faddr;
    bit          m_redir;
    logic [31:0] m_tgt;
    logic [31:0] m_nxt;
    bit          m_want;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  = 0;
            m_pc    = RV;
            m_cnt   = 0;
            m_faddr = 0;
            m_redir = 0;
        end else begin
            m_redir = 0;
            if (m_mode == 0) begin
                m_want = jalr_taken || branch_taken;
                if (jalr_taken) m_tgt = (jalr_base + jalr_imm) & 32'hFFFF_FFFE;
                else            m_tgt = branch_pc + branch_offset;
                if (m_want && ((m_tgt % 4) >= 2)) begin
                    m_mode  = 2;
                    m_faddr = m_tgt;
                end else begin
                    if (m_want)      m_nxt = m_tgt;
                    else if (stall)  m_nxt = m_pc;
                    else             m_nxt = m_pc + 4;
                    if (m_nxt != m_pc) m_cnt = m_cnt + 1;
                    m_pc    = m_nxt;
                    m_redir = m_want;
                    if (halt_req) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (resume && !halt_req) m_mode = 0;
            end
        end
    end

    // Compare DUT against model away from the active edge
    always @(negedge clk) begin
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("pc_valid", {31'd0, pc_valid}, {31'd0, (m_mode == 0) && !stall});
        check("redirect", {31'd0, redirect}, {31'd0, m_redir});
        check("halted", {31'd0, halted}, {31'd0, m_mode == 1});
        check("fault", {31'd0, fault}, {31'd0, m_mode == 2});
        check("fault_addr", fault_addr, m_faddr);
        check("fetch_count", fetch_count, m_cnt);
    end

    task automatic drive(input bit st, input bit bt, input logic [31:0] bpc, input logic [31:0] boff,
                         input bit jt, input logic [31:0] jb, input logic [31:0] ji,
                         input bit hr, input bit rs);
        stall         = st;
        branch_taken  = bt;
        branch_pc     = bpc;
        branch_offset = boff;
        jalr_taken    = jt;
        jalr_base     = jb;
        jalr_imm      = ji;
        halt_req      = hr;
        resume        = rs;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_faddr", fault_addr, 32'h0);

        // Sequential fetch
        tick(); check("seq_pc1", pc, 32'h4);
        tick(); check("seq_pc2", pc, 32'h8);
        tick(); check("seq_pc3", pc, 32'hC);
        check("seq_count", fetch_count, 32'd3);
        tick(); check("seq_pc4", pc, 32'h10);

        // Branch beats stall
        drive(1, 1, 32'h8, 32'h20, 0, 0, 0, 0, 0);
        #1 check("stall_valid", {31'd0, pc_valid}, 32'd0);
        tick();
        check("br_pc", pc, 32'h28);
        check("br_redirect", {31'd0, redirect}, 32'd1);
        check("br_count", fetch_count, 32'd5);
        idle();
        tick();
        check("br_redirect_end", {31'd0, redirect}, 32'd0);
        check("br_next_pc", pc, 32'h2C);

        // JALR beats branch, bit 0 cleared
        drive(0, 1, 32'h0, 32'h40, 1, 32'h101, 32'h4, 0, 0);
        tick(); check("jalr_pc", pc, 32'h104);

        // Halt sequence
        drive(0, 0, 0, 0, 1, 32'h20, 32'h0, 0, 0);
        tick(); check("to20_pc", pc, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check("halt_pc", pc, 32'h24);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, pc_valid}, 32'd0);
        drive(0, 1, 32'h400, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); check("halt_hold", pc, 32'h24);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick(); check("halt_both", {31'd0, halted}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("resume_flag", {31'd0, halted}, 32'd0);
        check("resume_pc", pc, 32'h24);
        idle();
        tick(); check("resume_next", pc, 32'h28);

        // Wrap and async reset
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
        tick(); check("wrap_pre", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        idle();
        tick(); check("wrap_pc", pc, 32'h0);
        tick(); check("wrap_next", pc, 32'h4);
        #1 rst = 1'b1;
        #1;
        check("arst_pc", pc, RV);
        check("arst_count", fetch_count, 32'h0);
        tick();
        rst = 1'b0;
        tick(); check("post_rst_pc", pc, RV + 32'h4);

        // Misaligned JALR traps and sticks
        drive(0, 0, 0, 0, 1, 32'h100, 32'h2, 0, 0);
        tick();
        check("fault_flag", {31'd0, fault}, 32'd1);
        check("fault_addr_cap", fault_addr, 32'h102);
        check("fault_pc", pc, 32'h4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h200, 32'h0, 1, 32'h300, 32'h0, 1, 1);
            tick();
            check("fault_sticky", {31'd0, fault}, 32'd1);
            check("fault_pc_hold", pc, 32'h4);
            check("fault_addr_hold", fault_addr, 32'h102);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] boff;
            logic [31:0] jimm;
            boff = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            jimm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC, boff,
                  $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC, jimm,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
